// File: rtl/alarm_siren_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_siren_ctrl
// Purpose  : Output stage that follows the combinational alarm decision
//            logic. The raw ALARM level is qualified by an entry delay. Once
//            qualified, the block latches a trip and drives the siren for a
//            bounded time, with a strobe lamp. It then rests in a silent
//            tripped state until the user disarms. A panic request skips the
//            entry delay.
//
// Ports    : CLK       in   system clock, rising edge
//            RESET_N   in   asynchronous active-low reset
//            ALARM_IN  in   alarm level from upstream (synchronous)
//            PANIC_IN  in   panic request, skips the entry delay
//            DISARM    in   user disarm level, highest priority
//            SIREN     out  siren drive
//            STROBE    out  blinking lamp drive
//            TRIPPED   out  latched "alarm has occurred" flag
//            STATE     out  IDLE=0, PENDING=1, SOUNDING=2, SILENT=3
//
// Revision : 1.0  initial release
// ============================================================================
module alarm_siren_ctrl #(
  parameter int ENTRY_DELAY = 4,
  parameter int SIREN_TIME  = 8,
  parameter int STROBE_BIT  = 1,
  parameter int CNT_W       = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ALARM_IN,
  input  logic       PANIC_IN,
  input  logic       DISARM,
  output logic       SIREN,
  output logic       STROBE,
  output logic       TRIPPED,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PENDING  = 2'd1,
    ST_SOUNDING = 2'd2,
    ST_SILENT   = 2'd3
  } state_t;

  // Terminal counts, compared before the increment so that the counter
  // never reaches ENTRY_DELAY or SIREN_TIME themselves.
  localparam logic [CNT_W-1:0] c_entry_last = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] c_siren_last = CNT_W'(SIREN_TIME - 1);
  localparam logic [CNT_W-1:0] c_cnt_zero   = '0;
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_tripped;
  logic             w_tripped_nxt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_tripped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tripped <= w_tripped_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tripped_nxt = r_tripped;

    if (DISARM) begin
      // Disarm wins over everything, including a simultaneous panic.
      w_state_nxt   = ST_IDLE;
      w_cnt_nxt     = c_cnt_zero;
      w_tripped_nxt = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (PANIC_IN) begin
            w_state_nxt = ST_SOUNDING;
            w_cnt_nxt   = c_cnt_zero;
          end else if (ALARM_IN) begin
            // The first qualifying edge already counts as one.
            w_state_nxt = ST_PENDING;
            w_cnt_nxt   = c_cnt_one;
          end
        end

        ST_PENDING: begin
          if (PANIC_IN) begin
            w_state_nxt = ST_SOUNDING;
            w_cnt_nxt   = c_cnt_zero;
          end else if (!ALARM_IN) begin
            // Any gap restarts qualification from scratch.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = c_cnt_zero;
          end else if (r_cnt == c_entry_last) begin
            w_state_nxt = ST_SOUNDING;
            w_cnt_nxt   = c_cnt_zero;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end

        ST_SOUNDING: begin
          // Inputs are ignored here so that an episode cannot be stretched.
          if (r_cnt == c_siren_last) begin
            w_state_nxt = ST_SILENT;
            w_cnt_nxt   = c_cnt_zero;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end

        ST_SILENT: begin
          w_cnt_nxt = c_cnt_zero;
          if (ALARM_IN || PANIC_IN) begin
            w_state_nxt = ST_SOUNDING;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = c_cnt_zero;
        end
      endcase

      // The trip is latched on whichever edge enters SOUNDING.
      if (w_state_nxt == ST_SOUNDING) begin
        w_tripped_nxt = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Moore outputs, decoded from registered state only
  // --------------------------------------------------------------------------
  assign SIREN   = (r_state == ST_SOUNDING);
  assign STROBE  = SIREN & r_cnt[STROBE_BIT];
  assign TRIPPED = r_tripped;
  assign STATE   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alarm_siren_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_siren_ctrl
// Purpose  : Self-checking bench for alarm_siren_ctrl. A behavioural model
//            tracks "consecutive alarm edges" and "cycles spent sounding".
//            The DUT is compared against it on every falling clock edge.
//            Directed scenarios add hand-computed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_alarm_siren_ctrl;

  localparam int ENTRY_DELAY = 4;
  localparam int SIREN_TIME  = 8;
  localparam int STROBE_BIT  = 1;
  localparam int CNT_W       = 16;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       ALARM_IN = 1'b0;
  logic       PANIC_IN = 1'b0;
  logic       DISARM = 1'b0;
  logic       SIREN;
  logic       STROBE;
  logic       TRIPPED;
  logic [1:0] STATE;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  alarm_siren_ctrl #(
    .ENTRY_DELAY(ENTRY_DELAY),
    .SIREN_TIME (SIREN_TIME),
    .STROBE_BIT (STROBE_BIT),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .ALARM_IN(ALARM_IN),
    .PANIC_IN(PANIC_IN),
    .DISARM  (DISARM),
    .SIREN   (SIREN),
    .STROBE  (STROBE),
    .TRIPPED (TRIPPED),
    .STATE   (STATE)
  );

  always #5 CLK = ~CLK;

  // --------------------------------------------------------------------------
  // Behavioural model: mode (0 idle, 1 qualifying, 2 sounding, 3 silent),
  // number of consecutive alarm edges seen, and cycles already spent sounding.
  // --------------------------------------------------------------------------
  int m_mode    = 0;
  int m_qual    = 0;
  int m_elapsed = 0;
  bit m_trip    = 1'b0;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_mode    <= 0;
      m_qual    <= 0;
      m_elapsed <= 0;
      m_trip    <= 1'b0;
    end else if (DISARM) begin
      m_mode    <= 0;
      m_qual    <= 0;
      m_elapsed <= 0;
      m_trip    <= 1'b0;
    end else if (m_mode == 2) begin
      if (m_elapsed + 1 >= SIREN_TIME) begin
        m_mode    <= 3;
        m_elapsed <= 0;
      end else begin
        m_elapsed <= m_elapsed + 1;
      end
    end else if (PANIC_IN || (m_mode == 3 && ALARM_IN) ||
                 (ALARM_IN && m_qual + 1 >= ENTRY_DELAY)) begin
      m_mode    <= 2;
      m_elapsed <= 0;
      m_qual    <= 0;
      m_trip    <= 1'b1;
    end else if (m_mode == 3) begin
      m_mode <= 3;
    end else if (ALARM_IN) begin
      m_mode <= 1;
      m_qual <= m_qual + 1;
    end else begin
      m_mode <= 0;
      m_qual <= 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    if (cmp_en) begin
      check("model_state",   int'(STATE),   m_mode);
      check("model_siren",   int'(SIREN),   int'(m_mode == 2));
      check("model_strobe",  int'(STROBE),
            (m_mode == 2) ? ((m_elapsed / (1 << STROBE_BIT)) % 2) : 0);
      check("model_tripped", int'(TRIPPED), int'(m_trip));
    end
  end

  // Apply inputs, let one rising edge consume them, and return just after
  // the following falling edge. Outputs then reflect that edge.
  task automatic tick(input bit a, input bit p, input bit d);
    ALARM_IN = a;
    PANIC_IN = p;
    DISARM   = d;
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] strobe_seen;
    int         siren_cycles;

    // Reset state
    #1;
    cmp_en = 1'b1;
    check("reset_state",   int'(STATE),   0);
    check("reset_siren",   int'(SIREN),   0);
    check("reset_tripped", int'(TRIPPED), 0);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    RESET_N = 1'b1;

    // 1. Entry delay abort
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    check("t1_pending", int'(STATE), 1);
    check("t1_siren",   int'(SIREN), 0);
    tick(0, 0, 0);
    check("t1_idle",    int'(STATE),   0);
    check("t1_tripped", int'(TRIPPED), 0);

    // 2. Full episode with alarm held high
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    check("t2_siren_before", int'(SIREN), 0);
    tick(1, 0, 0);
    strobe_seen  = '0;
    siren_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      strobe_seen[i] = STROBE;
      if (SIREN) siren_cycles++;
      tick(1, 0, 0);
    end
    check("t2_siren_len",   siren_cycles,       8);
    check("t2_strobe_pat",  int'(strobe_seen),  8'hCC);
    check("t2_silent",      int'(STATE),        3);
    check("t2_siren_off",   int'(SIREN),        0);
    check("t2_tripped",     int'(TRIPPED),      1);

    // 4. Re-trigger from SILENT (ALARM_IN still high)
    tick(1, 0, 0);
    check("t4_resound", int'(STATE), 2);
    siren_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (SIREN) siren_cycles++;
      tick(0, 0, 0);
    end
    check("t4_siren_len", siren_cycles, 8);
    check("t4_silent",    int'(STATE),  3);

    // Disarm from SILENT
    tick(0, 0, 1);
    check("disarm_state",   int'(STATE),   0);
    check("disarm_tripped", int'(TRIPPED), 0);

    // 3. Panic pulse
    tick(0, 1, 0);
    check("t3_state",   int'(STATE),   2);
    check("t3_siren",   int'(SIREN),   1);
    check("t3_tripped", int'(TRIPPED), 1);
    tick(0, 0, 0);
    tick(0, 0, 0);

    // 5. Disarm together with panic during SOUNDING
    tick(0, 1, 1);
    check("t5_state",   int'(STATE),   0);
    check("t5_siren",   int'(SIREN),   0);
    check("t5_tripped", int'(TRIPPED), 0);

    // Alarm together with panic in IDLE
    tick(1, 1, 0);
    check("both_state", int'(STATE), 2);
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("t6_strobe_on", int'(STROBE), 1);

    // 6. Asynchronous reset between edges
    @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    check("t6_siren",   int'(SIREN),   0);
    check("t6_strobe",  int'(STROBE),  0);
    check("t6_tripped", int'(TRIPPED), 0);
    check("t6_state",   int'(STATE),   0);
    @(negedge CLK);
    #1;
    RESET_N = 1'b1;
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    check("t6_wait", int'(SIREN), 0);
    tick(1, 0, 0);
    check("t6_sound", int'(SIREN), 1);

    // One low cycle in PENDING restarts qualification
    tick(0, 0, 1);
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    check("restart_wait", int'(SIREN), 0);
    tick(1, 0, 0);
    check("restart_sound", int'(SIREN), 1);
    tick(0, 0, 1);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
